pipe_fp_adder: RTL and testbench

- Parametrised, 3-stage pipelined floating-point adder/subtractor with valid/ready handshake on both sides.
- Next generation of the combinational FP summator:
  - generic exponent/mantissa widths;
  - add or subtract mode;
  - round-to-nearest-even;
  - IEEE-style special-value handling and status flags;
  - backpressure.
- Sits in the arithmetic datapath between an operand producer and a result consumer, issuing one operation per cycle when not stalled.

---
 rtl/struct_types.sv | 24 ++
 rtl/fp_lzc.sv | 19 +
 rtl/pipe_fp_adder.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_fp_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/struct_types.sv
// Shared arithmetic types: fp32 layout, status flags, operand classes and the
// canonical quiet NaN of the fp32 instance.
package struct_types;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_status_t;

  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;

  localparam logic [7:0]     FP32_QNAN_EXP  = 8'hFF;
  localparam logic [22:0]    FP32_QNAN_MANT = 23'h400000;
  localparam float_point_num FP32_QNAN      = '{sign: 1'b0, exp: FP32_QNAN_EXP, mant: FP32_QNAN_MANT};

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]       value,
  output logic [$clog2(WIDTH):0] count
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/pipe_fp_adder.sv
// Three-stage pipelined floating-point add/subtract: align, add/normalise,
// round/pack. Special operands ride down the pipe as a precomputed result.
module pipe_fp_adder
  import struct_types::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [EXP_W+MANT_W:0]   a_i,
  input  logic [EXP_W+MANT_W:0]   b_i,
  input  logic                    op_i,
  input  logic                    vld_i,
  output logic                    rdy_o,
  output logic [EXP_W+MANT_W:0]   answer_o,
  output logic [3:0]              answer_status_o,
  output logic                    vld_o,
  input  logic                    rdy_i
);

  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int AW = MANT_W + 4;            // hidden + mantissa + guard/round/sticky
  localparam int SW = MANT_W + 5;            // adder width including carry
  localparam int EW = EXP_W + 2;             // signed exponent with headroom
  localparam int LW = $clog2(AW) + 1;
  localparam logic [W-1:0] CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic signed [EW-1:0] MAX_EXP = EW'((1 << EXP_W) - 1);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    if (e == '0)                 return ZERO;
    else if (e != {EXP_W{1'b1}}) return NORM;
    else if (m == '0)            return INF;
    else if (m[MANT_W-1])        return QNAN;
    else                         return SNAN;
  endfunction

  // Handshake: an operand transfers on a rising edge with vld_i & rdy_o, a result
  // on vld_o & rdy_i; every stage advances together only when en is high.
  logic en;
  assign en    = ~vld_o | rdy_i;
  assign rdy_o = en;

  // ---------------- stage 1: unpack / classify / swap / align ----------------
  logic                    sa, sb, swap, big_s, small_s, spec_n;
  logic [EXP_W-1:0]        ea, eb, diff;
  logic [MANT_W-1:0]       ma, mb;
  fp_class_e               ca, cb;
  logic [EXP_W+MANT_W-1:0] mag_a, mag_b, big_mag, small_mag;
  logic [AW-1:0]           big_al, small_ext, small_sh, lost_mask, small_al;
  logic [W-1:0]            spec_res_n;
  fp_status_t              spec_st_n;

  always_comb begin
    sa        = a_i[W-1];
    ea        = a_i[W-2 -: EXP_W];
    ma        = a_i[MANT_W-1:0];
    sb        = b_i[W-1] ^ op_i;
    eb        = b_i[W-2 -: EXP_W];
    mb        = b_i[MANT_W-1:0];
    ca        = classify(ea, ma);
    cb        = classify(eb, mb);
    mag_a     = (ca == ZERO) ? '0 : a_i[W-2:0];
    mag_b     = (cb == ZERO) ? '0 : b_i[W-2:0];
    swap      = mag_b > mag_a;
    big_mag   = swap ? mag_b : mag_a;
    small_mag = swap ? mag_a : mag_b;
    big_s     = swap ? sb : sa;
    small_s   = swap ? sa : sb;
    diff      = big_mag[EXP_W+MANT_W-1 -: EXP_W] - small_mag[EXP_W+MANT_W-1 -: EXP_W];
    big_al    = {big_mag[EXP_W+MANT_W-1 -: EXP_W] != '0, big_mag[MANT_W-1:0], 3'b000};
    small_ext = {small_mag[EXP_W+MANT_W-1 -: EXP_W] != '0, small_mag[MANT_W-1:0], 3'b000};
    small_sh  = small_ext >> diff;
    lost_mask = ~({AW{1'b1}} << diff);
    small_al  = {small_sh[AW-1:1], small_sh[0] | (|(small_ext & lost_mask))};

    spec_n     = 1'b1;
    spec_res_n = '0;
    spec_st_n  = '0;
    if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN) begin
      spec_res_n        = CANON_QNAN;
      spec_st_n.invalid = (ca == SNAN) || (cb == SNAN);
    end else if (ca == INF && cb == INF && sa != sb) begin
      spec_res_n        = CANON_QNAN;
      spec_st_n.invalid = 1'b1;
    end else if (ca == INF) begin
      spec_res_n = {sa, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (cb == INF) begin
      spec_res_n = {sb, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (ca == ZERO && cb == ZERO) begin
      spec_res_n = {sa & sb, {(W-1){1'b0}}};
    end else begin
      spec_n = 1'b0;
    end
  end

  logic             v1, s1_spec, s1_sign, s1_sub;
  logic [W-1:0]     s1_res;
  fp_status_t       s1_st;
  logic [EXP_W-1:0] s1_exp;
  logic [AW-1:0]    s1_big, s1_small;

  // ---------------- stage 2: add / normalise ----------------
  logic [SW-1:0]          sum;
  logic [LW-1:0]          lz;
  logic [AW-1:0]          norm_n;
  logic signed [EW-1:0]   exp_n;

  fp_lzc #(.WIDTH(AW)) u_lzc (
    .value (sum[AW-1:0]),
    .count (lz)
  );

  always_comb begin
    sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small}) : ({1'b0, s1_big} + {1'b0, s1_small});
    if (sum[SW-1]) begin
      norm_n = {sum[SW-1:2], sum[1] | sum[0]};
      exp_n  = {2'b00, s1_exp} + EW'(1);
    end else begin
      norm_n = sum[AW-1:0] << lz;
      exp_n  = {2'b00, s1_exp} - EW'(lz);
    end
  end

  logic                 v2, s2_spec, s2_sign, s2_zero;
  logic [W-1:0]         s2_res;
  fp_status_t           s2_st;
  logic signed [EW-1:0] s2_exp;
  logic [AW-1:0]        s2_norm;

  // ---------------- stage 3: round / pack ----------------
  logic                 g, r, s, up;
  logic [MANT_W+1:0]    rnd;
  logic signed [EW-1:0] exp_r;
  logic [MANT_W-1:0]    mant_f;
  logic [W-1:0]         ans_n;
  fp_status_t           st_n;

  always_comb begin
    g      = s2_norm[2];
    r      = s2_norm[1];
    s      = s2_norm[0];
    up     = g & (r | s | s2_norm[3]);
    rnd    = {1'b0, s2_norm[AW-1:3]} + (MANT_W+2)'(up);
    exp_r  = s2_exp + EW'(rnd[MANT_W+1]);
    mant_f = rnd[MANT_W+1] ? rnd[MANT_W:1] : rnd[MANT_W-1:0];
    ans_n  = '0;
    st_n   = '0;
    if (s2_spec) begin
      ans_n = s2_res;
      st_n  = s2_st;
    end else if (s2_zero) begin
      ans_n = '0;
    end else if (s2_exp <= 0) begin
      ans_n          = {s2_sign, {(W-1){1'b0}}};
      st_n.underflow = 1'b1;
      st_n.inexact   = 1'b1;
    end else if (exp_r >= MAX_EXP) begin
      ans_n         = {s2_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      st_n.overflow = 1'b1;
      st_n.inexact  = 1'b1;
    end else begin
      ans_n        = {s2_sign, exp_r[EXP_W-1:0], mant_f};
      st_n.inexact = g | r | s;
    end
  end

  logic         v3;
  logic [W-1:0] s3_ans;
  logic [3:0]   s3_st;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= vld_i;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      s1_spec  <= spec_n;
      s1_res   <= spec_res_n;
      s1_st    <= spec_st_n;
      s1_sign  <= big_s;
      s1_sub   <= big_s ^ small_s;
      s1_exp   <= big_mag[EXP_W+MANT_W-1 -: EXP_W];
      s1_big   <= big_al;
      s1_small <= small_al;
      s2_spec  <= s1_spec;
      s2_res   <= s1_res;
      s2_st    <= s1_st;
      s2_sign  <= s1_sign;
      s2_zero  <= (sum == '0);
      s2_exp   <= exp_n;
      s2_norm  <= norm_n;
      s3_ans   <= ans_n;
      s3_st    <= st_n;
    end
  end

  // Stale data of an empty output stage is masked so idle outputs read zero.
  assign vld_o           = v3;
  assign answer_o        = v3 ? s3_ans : '0;
  assign answer_status_o = v3 ? s3_st : 4'b0000;

endmodule

// File: tb/tb_pipe_fp_adder.sv
// Bench for pipe_fp_adder (fp32 instance): exact-arithmetic reference model,
// scoreboard queue, directed vectors, backpressure and reset scenarios.
module tb_pipe_fp_adder;
  import struct_types::*;

  logic        clk = 1'b0;
  logic        rst_i, op_i, vld_i, rdy_o, vld_o, rdy_i;
  logic [31:0] a_i, b_i, answer_o;
  logic [3:0]  answer_status_o;

  pipe_fp_adder #(.EXP_W(8), .MANT_W(23)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .op_i            (op_i),
    .vld_i           (vld_i),
    .rdy_o           (rdy_o),
    .answer_o        (answer_o),
    .answer_status_o (answer_status_o),
    .vld_o           (vld_o),
    .rdy_i           (rdy_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [35:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_cnt = 0;
  logic        held = 1'b0;
  logic [35:0] held_val;
  logic [35:0] want;

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, got, req);
    end
  endtask

  // Reference: the exact sum as a wide integer in units of 2^-149, then RNE.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic         sa, sb, s, inexact, up, nan_a, nan_b, snan_a, snan_b;
    logic [7:0]   ea, eb;
    logic [22:0]  ma, mb;
    logic [287:0] ia, ib, mag, kept, rem, mask, half;
    int           p, ex, sh;
    sa = a[31]; sb = b[31] ^ op;
    ea = a[30:23]; eb = b[30:23];
    ma = a[22:0];  mb = b[22:0];
    nan_a  = (ea == 8'hFF) && (ma != 0);
    nan_b  = (eb == 8'hFF) && (mb != 0);
    snan_a = nan_a && !ma[22];
    snan_b = nan_b && !mb[22];
    if (nan_a || nan_b) return {snan_a | snan_b, 3'b000, FP32_QNAN};
    if (ea == 8'hFF && eb == 8'hFF)
      return (sa != sb) ? {4'b1000, FP32_QNAN} : {4'b0000, sa, 8'hFF, 23'd0};
    if (ea == 8'hFF) return {4'b0000, sa, 8'hFF, 23'd0};
    if (eb == 8'hFF) return {4'b0000, sb, 8'hFF, 23'd0};
    ia = (ea == 0) ? '0 : (288'({1'b1, ma}) << (ea - 8'd1));
    ib = (eb == 0) ? '0 : (288'({1'b1, mb}) << (eb - 8'd1));
    if (sa == sb)      begin mag = ia + ib; s = sa; end
    else if (ia >= ib) begin mag = ia - ib; s = sa; end
    else               begin mag = ib - ia; s = sb; end
    if (mag == 0) return {4'b0000, sa & sb, 31'd0};
    p = 0;
    for (int i = 0; i < 288; i++) if (mag[i]) p = i;
    ex = p - 22;
    if (ex <= 0) return {4'b0011, s, 31'd0};
    sh      = p - 23;
    kept    = mag >> sh;
    mask    = ~({288{1'b1}} << sh);
    rem     = mag & mask;
    inexact = (rem != 0);
    up      = 1'b0;
    if (sh > 0) begin
      half = 288'(1) << (sh - 1);
      up   = (rem > half) || ((rem == half) && kept[0]);
    end
    kept = kept + 288'(up);
    if (kept[24]) begin kept = kept >> 1; ex++; end
    if (ex >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    return {3'b000, inexact, s, 8'(ex), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)), 23'($urandom)};
      1:       return {1'($urandom_range(0, 1)), 8'($urandom_range(251, 254)), 23'($urandom)};
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 130)), 23'($urandom)};
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op);
    int waited = 0;
    a_i = a; b_i = b; op_i = op; vld_i = 1'b1;
    @(negedge clk);
    while (!rdy_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy_o) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: rdy_o actual 0 required 1 within 50 cycles");
    end else begin
      exp_q.push_back(model(a, b, op));
    end
    @(posedge clk);
    #1 vld_i = 1'b0;
  endtask

  // Call right after issue() on an empty pipe; the accepting edge counts as 1.
  task automatic expect_latency(input string name, input logic [35:0] lit);
    int edges = 1;
    @(negedge clk);
    while (!vld_o && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check({name, "_latency"}, 36'(edges), 36'd3);
    check({name, "_value"}, {answer_status_o, answer_o}, lit);
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_vld", 36'(vld_o), 36'd1);
          check("hold_value", {answer_status_o, answer_o}, held_val);
        end
        if (vld_o && !rdy_i) begin
          stall_cnt++;
          check("rdy_o_stall", 36'(rdy_o), 36'd0);
          held     = 1'b1;
          held_val = {answer_status_o, answer_o};
        end else begin
          held = 1'b0;
        end
        if (vld_o && rdy_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: actual %h required none", {answer_status_o, answer_o});
          end else begin
            want = exp_q.pop_front();
            check("result", {answer_status_o, answer_o}, want);
          end
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  logic [31:0] dir_a [15] = '{32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h00800000,
                              32'h3F800000, 32'h7F800001, 32'h7FC00000, 32'h80000000, 32'hFF800000,
                              32'h00000001, 32'h4B800000, 32'h3F800000, 32'h7F800000, 32'hC0000000};
  logic [31:0] dir_b [15] = '{32'h3F800000, 32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h00800001,
                              32'h3F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000,
                              32'h3F800000, 32'h3F800000, 32'h33800001, 32'hFF800000, 32'h3F800000};
  logic        dir_op[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [35:0] dir_e [15] = '{36'h0_00000000, 36'h1_3F800000, 36'h5_7F800000, 36'h8_7FC00000, 36'h3_80000000,
                              36'h0_33800000, 36'h8_7FC00000, 36'h0_7FC00000, 36'h0_80000000, 36'h0_FF800000,
                              36'h0_3F800000, 36'h1_4B800000, 36'h1_3F800001, 36'h0_7F800000, 36'h0_BF800000};

  task automatic drain(input string name);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    check(name, 36'(exp_q.size()), 36'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b1; vld_i = 1'b0; rdy_i = 1'b1; op_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_vld_o", 36'(vld_o), 36'd0);
    check("reset_answer", {answer_status_o, answer_o}, 36'd0);
    check("reset_rdy_o", 36'(rdy_o), 36'd1);
    @(posedge clk);
    #1;

    // Pin the reference model against hand-derived results.
    check("pin_add", model(32'h3F600000, 32'h400CCCCD, 1'b0), 36'h0_4044CCCD);
    for (int i = 0; i < 15; i++) check($sformatf("pin_dir%0d", i), model(dir_a[i], dir_b[i], dir_op[i]), dir_e[i]);

    // First op with latency measurement.
    issue(32'h3F600000, 32'h400CCCCD, 1'b0);
    expect_latency("first_add", 36'h0_4044CCCD);
    drain("drain_first");

    // Directed vectors back-to-back.
    for (int i = 0; i < 15; i++) issue(dir_a[i], dir_b[i], dir_op[i]);
    drain("drain_directed");

    // Backpressure: five ops with a 4-cycle consumer stall in the middle.
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) issue(32'h3F800000 + 32'(i << 20), 32'h40400000 + 32'(i << 19), 1'(i % 2));
      end
      begin
        repeat (3) @(posedge clk);
        #1 rdy_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rdy_i = 1'b1;
      end
    join
    drain("drain_backpressure");
    check("stall_observed", 36'(stall_cnt > 0), 36'd1);

    // Reset with three ops in flight.
    rdy_i = 1'b0;
    issue(32'h3F800000, 32'h40000000, 1'b0);
    issue(32'h40400000, 32'h3F800000, 1'b1);
    issue(32'h41200000, 32'h41200000, 1'b0);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    exp_q.delete();
    rdy_i = 1'b1;
    @(negedge clk);
    check("midreset_vld_o", 36'(vld_o), 36'd0);
    check("midreset_answer", {answer_status_o, answer_o}, 36'd0);
    check("midreset_rdy_o", 36'(rdy_o), 36'd1);
    @(posedge clk);
    #1;
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    expect_latency("after_reset", 36'h0_40000000);
    drain("drain_after_reset");

    // Mixed operands under random consumer stalls.
    fork
      begin
        for (int i = 0; i < 40; i++) issue(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(posedge clk);
          #1 rdy_i = 1'($urandom_range(0, 1));
        end
        rdy_i = 1'b1;
      end
    join
    rdy_i = 1'b1;
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
